fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decoder. It owns the program counter and a synchronous-read instruction memory, and presents one 16-bit instruction at a time to the decoder over a valid/ready handshake. It also applies branch redirects from execute, supports halt, and provides a program-load port that is writable only while halted.

Parameters:
ADDR_W, 8, instruction-memory address width; depth = 2**ADDR_W words; PC wraps modulo depth
DATA_W, 16, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
instr  output  DATA_W  instruction word presented to the decoder
instr_pc  output  ADDR_W  address from which instr was fetched
instr_valid  output  1  instr/instr_pc are valid
instr_ready  input  1  decoder accepts on the edge where instr_valid && instr_ready
redirect  input  1  one-cycle branch pulse from execute
redirect_rel  input  1  1: target = pc + redirect_off; 0: target = redirect_off
redirect_off  input  16  signed offset or absolute target; truncated to ADDR_W
halt_req  input  1  level request to stop fetching
halted  output  1  fetch is stopped; program port is live
prog_we  input  1  instruction-memory write strobe
prog_addr  input  ADDR_W  write address
prog_data  input  DATA_W  write data
fetch_count  output  16  accepted-instruction count (see optional feature)

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - pc = RESET_PC; state = FETCH.
  - instr = 0, instr_pc = 0, instr_valid = 0, halted = 0, fetch_count = 0.
  - Reset overrides all other inputs and discards any in-flight read.
- Instruction memory: DATA_W x 2**ADDR_W array with one synchronous read port (address pc) and one synchronous write port (prog_*). Contents are not cleared by reset.
- FSM states: FETCH, VALID, HALTED.
  - FETCH:
    - If halt_req: go to HALTED.
    - Otherwise: issue a read at pc. Next cycle: instr = mem[pc], instr_pc = pc, instr_valid = 1, state = VALID.
    - Latency from entering FETCH to instr_valid is 1 cycle.
  - VALID:
    - instr, instr_pc and instr_valid hold stable until accepted.
    - On accept: pc <= pc + 1 (mod 2**ADDR_W), instr_valid <= 0.
    - After accept: go to HALTED if halt_req, else FETCH.
    - Peak throughput is 1 instruction per 2 cycles, matching the CPU's 2-phase fetch/execute.
  - HALTED:
    - halted = 1, instr_valid = 0.
    - When halt_req deasserts: halted <= 0, state = FETCH, fetch resumes at the current pc.
- Redirect, any non-HALTED state:
  - Next cycle: pc = target, instr_valid = 0, state = FETCH.
  - In FETCH, the in-flight read is discarded.
  - In VALID, the held instruction is dropped. If instr_ready is also high on that edge, the instruction is still counted as accepted, but pc takes target, not pc + 1.
  - Target arithmetic: 16-bit add of zero-extended pc and redirect_off, then the low ADDR_W bits. Wrap-around is legal, e.g. pc = 0 with off = -1 gives target 2**ADDR_W - 1.
- Redirect while HALTED: pc updates, state stays HALTED.
- Priority: reset > redirect > halt_req > accept.
- Program port:
  - prog_we writes mem[prog_addr] = prog_data only while halted = 1.
  - Writes in other states are ignored.
  - Data written is visible to the first fetch after leaving HALTED.
- instr_ready while instr_valid = 0 has no effect.

Optional Feature:
- FETCH_COUNT_EN defined: fetch_count increments by 1 (wrapping at 16'hFFFF -> 0) on each accepted handshake, including an accept coincident with redirect. Reset clears it to 0.
- Not defined: fetch_count is tied to 0 and no counter register exists.

Test Plan:
1. Preload mem[0..2] = 16'h1111, 16'h2222, 16'h3333; hold instr_ready = 1 -> instr sequence 1111/2222/3333 with instr_pc 0/1/2; instr_valid high every other cycle.
2. instr_ready = 0 for 5 cycles with instr = 16'h2222 pending -> instr and instr_pc stay stable with valid = 1; pc stays 1. Then ready = 1 -> accept, next instr_pc = 2.
3. At pc = 5, redirect = 1, rel = 1, off = 16'hFFFD -> next instr_pc = 2. Absolute redirect with off = 16'h01F0 and ADDR_W = 8 -> instr_pc = 8'hF0.
4. At pc = 8'hFF, accept -> next instr_pc = 8'h00 (wrap).
5. Assert halt_req -> halted = 1 after the current accept. Write prog_addr = 3, data = 16'hABCD -> write happens. Write while not halted -> mem unchanged. Release halt_req -> fetch resumes at the pending pc and reads ABCD at address 3.
6. Assert reset mid-VALID -> next cycle instr_valid = 0, pc = RESET_PC, fetch_count = 0 (FETCH_COUNT_EN defined: count of 3 accepts reads 3 before reset).

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: decoder handshake, execute redirect, halt control and program-load port.
// master = fetch unit side, slave = decoder / control / loader side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic              redirect_rel;
  logic [15:0]       redirect_off;
  logic              halt_req;
  logic              halted;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [15:0]       fetch_count;

  modport master (
    output instr, instr_pc, instr_valid, halted, fetch_count,
    input  instr_ready, redirect, redirect_rel, redirect_off, halt_req,
           prog_we, prog_addr, prog_data
  );

  modport slave (
    input  instr, instr_pc, instr_valid, halted, fetch_count,
    output instr_ready, redirect, redirect_rel, redirect_off, halt_req,
           prog_we, prog_addr, prog_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, sync-read instruction memory, valid/ready handoff to decode.
// Optional macro FETCH_COUNT_EN enables the accepted-instruction counter on fetch_count.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_VALID  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              valid_q;
  logic              halted_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_next_seq;

  assign accept      = (state == ST_VALID) && bus.instr_ready;
  assign pc_next_seq = pc + ADDR_W'(1);

  // Low ADDR_W bits of the 16-bit sum equal the ADDR_W-bit sum, so no wide adder is needed.
  always_comb begin
    target = bus.redirect_off[ADDR_W-1:0];
    if (bus.redirect_rel) begin
      target = pc + bus.redirect_off[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.prog_we && halted_q) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.redirect) begin
            pc <= target;
          end else if (bus.halt_req) begin
            state    <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            instr_q    <= mem[pc];
            instr_pc_q <= pc;
            valid_q    <= 1'b1;
            state      <= ST_VALID;
          end
        end
        ST_VALID: begin
          // A pending halt waits for the held instruction to be taken.
          if (bus.redirect) begin
            pc      <= target;
            valid_q <= 1'b0;
            state   <= ST_FETCH;
          end else if (accept) begin
            pc      <= pc_next_seq;
            valid_q <= 1'b0;
            if (bus.halt_req) begin
              state    <= ST_HALTED;
              halted_q <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          if (bus.redirect) begin
            pc <= target;
          end else if (!bus.halt_req) begin
            halted_q <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        default: begin
          state    <= ST_FETCH;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] count_q;

  // Counts the handshake even when a same-edge redirect drops the instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign bus.fetch_count = count_q;
`else
  assign bus.fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver queues expected (instr, instr_pc) pairs,
// monitor pops one per new presentation and checks hold stability while stalled.
module tb_fetch_unit;
  logic clk;
  logic reset;

  fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  exp_t exp_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [15:0] i, input logic [7:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    exp_q.push_back(e);
  endfunction

  function automatic logic [15:0] cnt(input int unsigned n);
`ifdef FETCH_COUNT_EN
    return 16'(n);
`else
    return 16'h0000 & 16'(n);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int unsigned n = 0;
    while (bus.instr_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (bus.instr_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s: instr_valid got %b expected 1 within 10 cycles", name, bus.instr_valid);
    end
  endtask

  task automatic accept_one();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
  endtask

  task automatic prog_write(input logic [7:0] a, input logic [15:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic do_redirect(input logic rel, input logic [15:0] off);
    bus.redirect     = 1'b1;
    bus.redirect_rel = rel;
    bus.redirect_off = off;
    tick();
    bus.redirect = 1'b0;
  endtask

  // Monitor: one pop per rising presentation; while held, outputs must match that entry.
  initial begin
    logic        prev_v;
    exp_t        cur;
    prev_v    = 1'b0;
    cur.instr = '0;
    cur.pc    = '0;
    forever begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1 && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr: got instr %h pc %h expected no presentation",
                   bus.instr, bus.instr_pc);
        end else begin
          cur = exp_q.pop_front();
          check("instr", 32'(bus.instr), 32'(cur.instr));
          check("instr_pc", 32'(bus.instr_pc), 32'(cur.pc));
        end
      end else if (bus.instr_valid === 1'b1 && prev_v) begin
        check("hold_instr", 32'(bus.instr), 32'(cur.instr));
        check("hold_instr_pc", 32'(bus.instr_pc), 32'(cur.pc));
      end
      prev_v = (bus.instr_valid === 1'b1);
    end
  end

  initial begin
    reset            = 1'b1;
    bus.instr_ready  = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_rel = 1'b0;
    bus.redirect_off = '0;
    bus.halt_req     = 1'b1;
    bus.prog_we      = 1'b0;
    bus.prog_addr    = '0;
    bus.prog_data    = '0;

    tick();
    tick();
    check("reset_instr", 32'(bus.instr), 32'h0);
    check("reset_instr_pc", 32'(bus.instr_pc), 32'h0);
    check("reset_valid", 32'(bus.instr_valid), 32'h0);
    check("reset_halted", 32'(bus.halted), 32'h0);
    check("reset_count", 32'(bus.fetch_count), 32'h0);
    reset = 1'b0;
    tick();
    check("halted_after_reset", 32'(bus.halted), 32'h1);

    prog_write(8'h00, 16'h1111);
    prog_write(8'h01, 16'h2222);
    prog_write(8'h02, 16'h3333);
    prog_write(8'h03, 16'h4444);
    prog_write(8'h04, 16'h5555);
    prog_write(8'h05, 16'h6666);
    prog_write(8'hF0, 16'hF0F0);
    prog_write(8'hFF, 16'hFFFF);

    // Streaming with ready held high: valid every other cycle.
    push(16'h1111, 8'h00);
    push(16'h2222, 8'h01);
    push(16'h3333, 8'h02);
    bus.halt_req    = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    check("resume_halted", 32'(bus.halted), 32'h0);
    check("stream_v0", 32'(bus.instr_valid), 32'h0);
    tick(); check("stream_v1", 32'(bus.instr_valid), 32'h1);
    tick(); check("stream_v2", 32'(bus.instr_valid), 32'h0);
    tick(); check("stream_v3", 32'(bus.instr_valid), 32'h1);
    tick(); check("stream_v4", 32'(bus.instr_valid), 32'h0);
    tick(); check("stream_v5", 32'(bus.instr_valid), 32'h1);
    bus.halt_req = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("halt_after_accept_valid", 32'(bus.instr_valid), 32'h0);
    check("halt_after_accept", 32'(bus.halted), 32'h1);
    check("count_3", 32'(bus.fetch_count), 32'(cnt(3)));

    // Redirect while halted, then stall on 2222.
    do_redirect(1'b0, 16'h0001);
    check("redirect_halted_stays", 32'(bus.halted), 32'h1);
    push(16'h2222, 8'h01);
    bus.halt_req = 1'b0;
    wait_valid("stall_present");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(bus.instr_valid), 32'h1);
    end
    push(16'h3333, 8'h02);
    accept_one();
    wait_valid("after_stall");

    push(16'h4444, 8'h03);
    accept_one();
    wait_valid("pc3");
    push(16'h5555, 8'h04);
    accept_one();
    wait_valid("pc4");
    push(16'h6666, 8'h05);
    accept_one();
    wait_valid("pc5");

    // Relative redirect from VALID at pc 5 by -3.
    push(16'h3333, 8'h02);
    do_redirect(1'b1, 16'hFFFD);
    check("rel_redirect_drop", 32'(bus.instr_valid), 32'h0);
    wait_valid("rel_target");

    // Absolute redirect with truncation, coincident with accept.
    push(16'hF0F0, 8'hF0);
    bus.instr_ready = 1'b1;
    do_redirect(1'b0, 16'h01F0);
    bus.instr_ready = 1'b0;
    check("abs_redirect_drop", 32'(bus.instr_valid), 32'h0);
    wait_valid("abs_target");

    // Redirect in FETCH discards the in-flight read of F1.
    push(16'hFFFF, 8'hFF);
    accept_one();
    do_redirect(1'b1, 16'h000E);
    check("fetch_redirect_drop", 32'(bus.instr_valid), 32'h0);
    wait_valid("fetch_redirect_target");

    // PC wrap FF -> 00, then relative target wrap 00 - 1 -> FF.
    push(16'h1111, 8'h00);
    accept_one();
    wait_valid("pc_wrap");
    push(16'hFFFF, 8'hFF);
    do_redirect(1'b1, 16'hFFFF);
    wait_valid("target_wrap");

    // Program port: ignored while fetching, live while halted.
    prog_write(8'h04, 16'hDEAD);
    bus.halt_req = 1'b1;
    tick();
    check("halt_waits_halted", 32'(bus.halted), 32'h0);
    check("halt_waits_valid", 32'(bus.instr_valid), 32'h1);
    accept_one();
    check("halt_entered", 32'(bus.halted), 32'h1);
    check("halt_valid_low", 32'(bus.instr_valid), 32'h0);
    prog_write(8'h03, 16'hABCD);
    do_redirect(1'b0, 16'h0003);
    push(16'hABCD, 8'h03);
    bus.halt_req = 1'b0;
    wait_valid("prog_written");
    push(16'h5555, 8'h04);
    accept_one();
    wait_valid("prog_ignored");
    check("count_12", 32'(bus.fetch_count), 32'(cnt(12)));

    // Reset mid-VALID.
    reset = 1'b1;
    tick();
    check("midreset_valid", 32'(bus.instr_valid), 32'h0);
    check("midreset_instr", 32'(bus.instr), 32'h0);
    check("midreset_instr_pc", 32'(bus.instr_pc), 32'h0);
    check("midreset_halted", 32'(bus.halted), 32'h0);
    check("midreset_count", 32'(bus.fetch_count), 32'h0);
    reset = 1'b0;
    push(16'h1111, 8'h00);
    wait_valid("after_reset_fetch");
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
